// File: rtl/fpnew_cast_arbiter_if.sv
// Channel bundle between the cast lanes, the arbiter and the shared cast pipeline.
// The arbiter connects through the slave modport; the lanes/pipeline side uses master.
interface fpnew_cast_arbiter_if #(
  parameter int unsigned NumLanes = 4,
  parameter int unsigned ReqWidth = 128,
  parameter int unsigned RspWidth = 72
);
  logic [NumLanes-1:0]               lane_req_valid_i;
  logic [NumLanes-1:0]               lane_req_ready_o;
  logic [NumLanes-1:0][ReqWidth-1:0] lane_req_data_i;
  logic                              unit_valid_o;
  logic                              unit_ready_i;
  logic [ReqWidth-1:0]               unit_data_o;
  logic                              unit_rsp_valid_i;
  logic                              unit_rsp_ready_o;
  logic [RspWidth-1:0]               unit_rsp_data_i;
  logic [NumLanes-1:0]               lane_rsp_valid_o;
  logic [NumLanes-1:0]               lane_rsp_ready_i;
  logic [RspWidth-1:0]               lane_rsp_data_o;

  modport slave (
    input  lane_req_valid_i, lane_req_data_i, unit_ready_i,
           unit_rsp_valid_i, unit_rsp_data_i, lane_rsp_ready_i,
    output lane_req_ready_o, unit_valid_o, unit_data_o,
           unit_rsp_ready_o, lane_rsp_valid_o, lane_rsp_data_o
  );

  modport master (
    output lane_req_valid_i, lane_req_data_i, unit_ready_i,
           unit_rsp_valid_i, unit_rsp_data_i, lane_rsp_ready_i,
    input  lane_req_ready_o, unit_valid_o, unit_data_o,
           unit_rsp_ready_o, lane_rsp_valid_o, lane_rsp_data_o
  );
endinterface

// File: rtl/fpnew_cast_arbiter.sv
// Shares one cast pipeline among NumLanes lanes; an in-order lane-ID queue routes results back.
// Define FPNEW_CAST_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.

module fpnew_cast_arbiter_chk (
  input logic clk_i,
  input logic rst_i,
  input logic unit_rsp_valid_i,
  input logic queue_empty_i
);
  rsp_needs_outstanding_id: assert property (
    @(posedge clk_i) disable iff (rst_i) !(unit_rsp_valid_i && queue_empty_i)
  ) else $warning("fpnew_cast_arbiter: unit_rsp_valid_i with no outstanding operation");
endmodule

module fpnew_cast_arbiter #(
  parameter int unsigned NumLanes       = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned ReqWidth       = 128,
  parameter int unsigned RspWidth       = 72
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  output logic                busy_o,
  fpnew_cast_arbiter_if.slave bus
);
  localparam int unsigned LaneW = $clog2(NumLanes);
  localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
  localparam logic [PtrW-1:0]  LastPtr  = PtrW'(MaxOutstanding - 1);
  localparam logic [CntW-1:0]  MaxCnt   = CntW'(MaxOutstanding);
  localparam logic [LaneW-1:0] LastLane = LaneW'(NumLanes - 1);

  logic [LaneW-1:0]    order_q_r [MaxOutstanding];
  logic [PtrW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CntW-1:0]     count_r;
  logic [LaneW-1:0]    start_s, grant_s, head_s;
  logic                any_valid_s, full_s, empty_s, push_s, pop_s;
  logic                unit_valid_s, unit_rsp_ready_s;
  logic [ReqWidth-1:0] unit_data_s;
  logic [RspWidth-1:0] rsp_data_s;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == LastPtr) ? {PtrW{1'b0}} : ptr + PtrW'(1'b1);
  endfunction

`ifdef FPNEW_CAST_ARB_FIXED_PRIO_EN
  assign start_s = {LaneW{1'b0}};
`else
  logic [LaneW-1:0] rr_ptr_r;
  assign start_s = rr_ptr_r;

  // Round-robin pointer: moves just past the lane that won the last accepted request.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rr_ptr_r <= {LaneW{1'b0}};
    end else if (push_s) begin
      rr_ptr_r <= (grant_s == LastLane) ? {LaneW{1'b0}} : grant_s + LaneW'(1'b1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`endif

  // Search from start_s upward with wrap; iterating backwards lets the nearest valid lane win.
  always_comb begin
    int idx_v;
    idx_v       = 0;
    grant_s     = start_s;
    any_valid_s = 1'b0;
    for (int i = int'(NumLanes) - 1; i >= 0; i--) begin
      idx_v = (int'(start_s) + i) % int'(NumLanes);
      if (bus.lane_req_valid_i[idx_v]) begin
        grant_s     = LaneW'(idx_v);
        any_valid_s = 1'b1;
      end else begin
      end
    end
  end

  assign full_s  = (count_r == MaxCnt);
  assign empty_s = (count_r == {CntW{1'b0}});
  assign head_s  = order_q_r[rd_ptr_r];

  // Request and result steering; both paths are purely combinational, flush blocks everything.
  always_comb begin
    unit_valid_s         = any_valid_s & ~full_s & ~flush_i;
    unit_data_s          = bus.lane_req_data_i[grant_s];
    push_s               = unit_valid_s & bus.unit_ready_i;
    bus.lane_req_ready_o = {NumLanes{1'b0}};
    if (push_s) begin
      bus.lane_req_ready_o[grant_s] = 1'b1;
    end else begin
    end
    unit_rsp_ready_s     = bus.lane_rsp_ready_i[head_s] & ~empty_s & ~flush_i;
    pop_s                = bus.unit_rsp_valid_i & unit_rsp_ready_s;
    bus.lane_rsp_valid_o = {NumLanes{1'b0}};
    if (bus.unit_rsp_valid_i && !empty_s && !flush_i) begin
      bus.lane_rsp_valid_o[head_s] = 1'b1;
    end else begin
    end
    rsp_data_s           = bus.unit_rsp_data_i;
  end

  assign bus.unit_valid_o     = unit_valid_s;
  assign bus.unit_data_o      = unit_data_s;
  assign bus.unit_rsp_ready_o = unit_rsp_ready_s;
  assign bus.lane_rsp_data_o  = rsp_data_s;
  assign busy_o               = ~empty_s | unit_valid_s;

  // Queue storage holds no control state, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      order_q_r[wr_ptr_r] <= grant_s;
    end
  end

  // Queue pointers and occupancy; reset and flush both drop every outstanding ID.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_r <= {PtrW{1'b0}};
      rd_ptr_r <= {PtrW{1'b0}};
      count_r  <= {CntW{1'b0}};
    end else begin
      wr_ptr_r <= push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
      rd_ptr_r <= pop_s  ? ptr_inc(rd_ptr_r) : rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CntW'(1'b1);
        2'b01:   count_r <= count_r - CntW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  fpnew_cast_arbiter_chk u_chk (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .unit_rsp_valid_i (bus.unit_rsp_valid_i),
    .queue_empty_i    (empty_s)
  );
endmodule

// File: doc/fpnew_cast_arbiter.md
FPNEW_CAST_ARBITER -- requirements
Module: fpnew_cast_arbiter

Interface
REQ-001 Parameter NumLanes, default 4: number of requesting lanes sharing one cast pipeline; legal range 2..16.
REQ-002 Parameter MaxOutstanding, default 4: depth of the lane-ID order queue; must be at least the cast pipeline's NumPipeRegs+1.
REQ-003 Parameter ReqWidth, default 128: packed width of the cast operand/control bundle.
REQ-004 Parameter RspWidth, default 72: packed width of the cast result/status bundle.
REQ-005 clk_i  in  1  sole clock, rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 lane_req_valid_i  in  NumLanes  per-lane request valid.
REQ-008 lane_req_ready_o  out  NumLanes  per-lane request ready.
REQ-009 lane_req_data_i  in  NumLanes x ReqWidth  per-lane request payload.
REQ-010 unit_valid_o / unit_ready_i / unit_data_o  out/in/out  1/1/ReqWidth  request channel to the shared cast pipeline.
REQ-011 unit_rsp_valid_i / unit_rsp_ready_o / unit_rsp_data_i  in/out/in  1/1/RspWidth  result channel from the cast pipeline.
REQ-012 lane_rsp_valid_o / lane_rsp_ready_i  out/in  NumLanes each  per-lane result handshake.
REQ-013 lane_rsp_data_o  out  RspWidth  result payload, broadcast to all lanes.
REQ-014 flush_i  in  1  synchronous flush, same cycle as the pipeline flush.
REQ-015 busy_o  out  1  high while any operation is outstanding.

Function
REQ-016 Request path SHALL be combinational: 0-cycle latency from lane_req to unit_valid_o/unit_data_o.
REQ-017 Grant SHALL select one valid lane per cycle; round-robin search starts at rr_ptr, wrapping from NumLanes-1 to 0.
REQ-018 unit_valid_o SHALL be high iff any lane is valid, the queue is not full, and flush_i is low; unit_data_o is the granted lane's payload.
REQ-019 lane_req_ready_o[g] SHALL equal unit_ready_i & unit_valid_o for the granted lane g only; all other bits are 0.
REQ-020 On a unit request handshake, rr_ptr SHALL update to (g+1) mod NumLanes and g SHALL be pushed to the order queue; otherwise rr_ptr holds.
REQ-021 Order queue SHALL be a FIFO of MaxOutstanding entries with a count register of width clog2(MaxOutstanding+1).
REQ-022 Full (count == MaxOutstanding): no push; unit_valid_o low, even when a pop occurs in the same cycle.
REQ-023 Simultaneous push and pop with count > 0: count unchanged, both pointers advance, each wrapping at MaxOutstanding.
REQ-024 Result path SHALL be combinational: lane_rsp_valid_o[h] = unit_rsp_valid_i & ~empty & ~flush_i for queue head h; other bits are 0.
REQ-025 unit_rsp_ready_o SHALL equal lane_rsp_ready_i[h] & ~empty & ~flush_i; a result handshake pops the head.
REQ-026 unit_rsp_valid_i while the queue is empty SHALL be a protocol error: it is not acknowledged, and an assertion fires.
REQ-027 busy_o SHALL equal (count != 0) | unit_valid_o.
REQ-028 A flush cycle SHALL accept no request, deliver no result, and empty the queue and reset rr_ptr to 0 at the next edge.
REQ-029 A flush asserted together with a request or result handshake attempt SHALL suppress that handshake; flush has priority.

Reset
REQ-030 While rst_i is high at a rising edge: rr_ptr=0, FIFO pointers=0, count=0.
REQ-031 After reset, all valid and ready outputs SHALL be 0 until inputs assert, and busy_o SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard all outstanding IDs without emitting any results.

Configuration
REQ-033 Macro FPNEW_CAST_ARB_FIXED_PRIO_EN, when defined: fixed priority, lowest index wins, and rr_ptr is not implemented.
REQ-034 Macro FPNEW_CAST_ARB_FIXED_PRIO_EN, when undefined: round-robin arbitration per REQ-017/REQ-020.

Verification
REQ-035 Lanes 0..3 all valid and unit_ready_i=1 held for 8 cycles -> grants 0,1,2,3,0,1,2,3; with the fixed-priority macro, grants are 0 every cycle.
REQ-036 MaxOutstanding=4, responses withheld, 6 requests offered -> exactly 4 accepted, unit_valid_o=0, busy_o=1.
REQ-037 Queue full, one result popped while a request is pending -> no push in the pop cycle, push in the next cycle, count back to 4.
REQ-038 Queue holds lanes 2,0; result arrives with lane_rsp_ready_i[2]=0 -> stall; when ready_i[2] rises, lane 2 receives first, then lane 0.
REQ-039 flush_i with 3 outstanding and lane 1 valid -> no handshake that cycle; next cycle count=0, rr_ptr=0, busy_o=0 if no lane is valid.
REQ-040 unit_rsp_valid_i=1 with the queue empty -> unit_rsp_ready_o=0, all lane_rsp_valid_o=0, assertion reported.
